// File: rtl/button_event_filter_pkg.sv
// Shared types and constants for the button event filter.
//   EVT_IDX_W : width of the button index carried by an event
//   TICK_MS   : debounce tick period in milliseconds
//   evt_t     : one queued event {index, press}
package button_event_pkg;

   localparam int EVT_IDX_W = 3;
   localparam int TICK_MS   = 1;

   typedef struct packed {
      logic [EVT_IDX_W-1:0] index;
      logic                 press;
   } evt_t;

endpackage

// File: rtl/button_event_filter_if.sv
// Event stream between the filter (master) and its consumer (slave).
//   valid : head event present
//   ready : consumer accepts head this cycle
//   index : button index of head event
//   press : 1 = press, 0 = release
interface button_event_filter_if;
   import button_event_pkg::*;

   logic                 valid;
   logic                 ready;
   logic [EVT_IDX_W-1:0] index;
   logic                 press;

   modport master (output valid, output index, output press, input ready);
   modport slave  (input valid, input index, input press, output ready);

endinterface

// File: rtl/button_event_filter_sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy.
//   i_clk, i_reset : clock, synchronous active-high reset
//   push/push_data : write request, ignored when full
//   pop            : read request, ignored when empty
//   head           : entry at the read pointer (valid when count != 0)
//   count          : occupancy, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/button_event_filter.sv
// Debounces raw button levels and queues press/release events.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_button         : raw levels, 1 = pressed
//   o_button_stable  : debounced levels
//   evt              : event stream (master), show-ahead FIFO head
//   o_fifo_count     : FIFO occupancy
//   o_overflow       : sticky; events merged or accepted while FIFO full
//   i_clr_overflow   : clears o_overflow (a same-cycle set wins)
module button_event_filter
   import button_event_pkg::*;
#(
   parameter int CLK_RATE_HZ    = 16_000_000,
   parameter int TICK_CYCLES    = CLK_RATE_HZ / 1000 * TICK_MS,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int NUM_BUTTONS    = 8,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [NUM_BUTTONS-1:0]      i_button,
   output logic [NUM_BUTTONS-1:0]      o_button_stable,
   button_event_filter_if.master       evt,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
   output logic                        o_overflow,
   input  logic                        i_clr_overflow
);
   localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DB_W    = $clog2(DEBOUNCE_TICKS);
   localparam int FC_W    = $clog2(FIFO_DEPTH) + 1;

   logic [PRESC_W-1:0]     presc;
   logic                   tick;
   logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] stable;
   logic [NUM_BUTTONS-1:0] pending;
   logic [NUM_BUTTONS-1:0] pend_press;
   logic [NUM_BUTTONS-1:0] accept;
   logic [NUM_BUTTONS-1:0] first_vec;
   logic [NUM_BUTTONS-1:0] grant_vec;
   logic                   grant_any;
   logic [EVT_IDX_W-1:0]   grant_idx;
   logic                   grant;
   logic [FC_W-1:0]        fifo_count;
   logic [FC_W-1:0]        occupancy;
   logic                   fifo_full;
   logic                   merge;
   logic                   held;
   logic                   push_q;
   evt_t                   push_d_q;
   evt_t                   head;

   assign tick = (presc == PRESC_W'(TICK_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset || tick) presc <= '0;
      else                 presc <= presc + PRESC_W'(1);
   end

   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
         accept[i] = tick && (i_button[i] != stable[i]) &&
                     (db_cnt[i] == DB_W'(DEBOUNCE_TICKS - 1));
   end

   // The push to the FIFO is registered, so an in-flight push already
   // occupies a slot; a same-cycle pop never frees room for a grant.
   assign occupancy = fifo_count + FC_W'(push_q);
   assign fifo_full = (occupancy >= FC_W'(FIFO_DEPTH));

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      first_vec = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (pending[i] && !grant_any) begin
            grant_any    = 1'b1;
            grant_idx    = EVT_IDX_W'(i);
            first_vec[i] = 1'b1;
         end
      end
   end

   assign grant     = grant_any && !fifo_full;
   assign grant_vec = grant ? first_vec : '0;

   // merge: a new level replaced an event still waiting in pending.
   // held: an event debounced while the FIFO had no room for it.
   assign merge = |(accept & pending & ~grant_vec);
   assign held  = (|accept) && fifo_full;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stable     <= '0;
         pending    <= '0;
         pend_press <= '0;
         push_q     <= 1'b0;
         push_d_q   <= '0;
         o_overflow <= 1'b0;
         for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (i_button[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (accept[i]) begin
               db_cnt[i]     <= '0;
               stable[i]     <= i_button[i];
               pend_press[i] <= i_button[i];
            end else if (tick) begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
         pending        <= (pending & ~grant_vec) | accept;
         push_q         <= grant;
         push_d_q.index <= grant_idx;
         push_d_q.press <= pend_press[grant_idx];
         if (merge || held)       o_overflow <= 1'b1;
         else if (i_clr_overflow) o_overflow <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .push      (push_q),
      .push_data (push_d_q),
      .pop       (evt.valid && evt.ready),
      .head      (head),
      .count     (fifo_count)
   );

   assign evt.valid       = (fifo_count != '0);
   assign evt.index       = head.index;
   assign evt.press       = head.press;
   assign o_fifo_count    = fifo_count;
   assign o_button_stable = stable;

endmodule

// File: tb/tb_button_event_filter.sv
module tb_button_event_filter;
   import button_event_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] btn;
   logic [7:0] stable;
   logic [2:0] fcount;
   logic       ovf;
   logic       clr;
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         n;
   logic [3:0] ev_q   [$];
   int         ev_cyc [$];

   always #5 clk = ~clk;

   button_event_filter_if evt ();

   button_event_filter #(
      .CLK_RATE_HZ    (16_000_000),
      .TICK_CYCLES    (4),
      .DEBOUNCE_TICKS (3),
      .NUM_BUTTONS    (8),
      .FIFO_DEPTH     (4)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_button        (btn),
      .o_button_stable (stable),
      .evt             (evt),
      .o_fifo_count    (fcount),
      .o_overflow      (ovf),
      .i_clr_overflow  (clr)
   );

   // Records every accepted event as {index, press} with its cycle number.
   always @(posedge clk) begin
      cyc++;
      if (evt.valid === 1'b1 && evt.ready === 1'b1) begin
         ev_q.push_back({evt.index, evt.press});
         ev_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic wait_stable(input logic [7:0] exp, input int max_cyc,
                              input string tag, output int cnt);
      cnt = 0;
      while (stable !== exp && cnt < max_cyc) begin
         step(1);
         cnt++;
      end
      check(tag, {24'd0, stable}, {24'd0, exp});
   endtask

   task automatic clear_log();
      ev_q.delete();
      ev_cyc.delete();
   endtask

   initial begin
      rst = 1'b1;
      btn = 8'h00;
      clr = 1'b0;
      evt.ready = 1'b1;
      step(3);
      check("rst_stable", {24'd0, stable}, 32'h0);
      check("rst_valid", {31'd0, evt.valid}, 32'h0);
      check("rst_count", {29'd0, fcount}, 32'h0);
      check("rst_ovf", {31'd0, ovf}, 32'h0);
      rst = 1'b0;
      step(2);

      // Press b2 and hold: debounce, then 2-cycle event latency.
      clear_log();
      btn = 8'h04;
      wait_stable(8'h04, 12, "t1_stable", n);
      check("t1_within_12", {31'd0, n <= 12}, 32'h1);
      check("t1_valid_lat0", {31'd0, evt.valid}, 32'h0);
      step(1);
      check("t1_valid_lat1", {31'd0, evt.valid}, 32'h0);
      step(1);
      check("t1_valid_lat2", {31'd0, evt.valid}, 32'h1);
      check("t1_index", {29'd0, evt.index}, 32'h2);
      check("t1_press", {31'd0, evt.press}, 32'h1);
      step(1);
      check("t1_count0", {29'd0, fcount}, 32'h0);
      check("t1_nevents", ev_q.size(), 32'h1);
      if (ev_q.size() >= 1) check("t1_event", {28'd0, ev_q[0]}, 32'h5);
      step(20);
      check("t1_hold", {24'd0, stable}, 32'h04);

      // Short glitch on b5 must be filtered.
      clear_log();
      btn = 8'h24;
      step(5);
      btn = 8'h04;
      step(20);
      check("t2_stable", {24'd0, stable}, 32'h04);
      check("t2_noevent", ev_q.size(), 32'h0);
      check("t2_ovf", {31'd0, ovf}, 32'h0);

      // Simultaneous press of b0, b3, b7: lowest index first, back to back.
      clear_log();
      btn = 8'h8D;
      wait_stable(8'h8D, 12, "t3_stable", n);
      step(6);
      check("t3_nevents", ev_q.size(), 32'h3);
      if (ev_q.size() == 3) begin
         check("t3_ev0", {28'd0, ev_q[0]}, 32'h1);
         check("t3_ev1", {28'd0, ev_q[1]}, 32'h7);
         check("t3_ev2", {28'd0, ev_q[2]}, 32'hF);
         check("t3_consec01", ev_cyc[1] - ev_cyc[0], 32'h1);
         check("t3_consec12", ev_cyc[2] - ev_cyc[1], 32'h1);
      end

      // Release everything: releases for 0, 2, 3, 7 in index order.
      clear_log();
      btn = 8'h00;
      wait_stable(8'h00, 12, "t3r_stable", n);
      step(8);
      check("t3r_nevents", ev_q.size(), 32'h4);
      if (ev_q.size() == 4) begin
         check("t3r_ev0", {28'd0, ev_q[0]}, 32'h0);
         check("t3r_ev1", {28'd0, ev_q[1]}, 32'h4);
         check("t3r_ev2", {28'd0, ev_q[2]}, 32'h6);
         check("t3r_ev3", {28'd0, ev_q[3]}, 32'hE);
      end

      // Backpressure: five toggles on b1 into a 4-deep FIFO.
      clear_log();
      evt.ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         btn[1] = (k % 2 == 0);
         wait_stable({6'd0, btn[1], 1'b0}, 12, "t4_stable", n);
         step(3);
      end
      check("t4_count_full", {29'd0, fcount}, 32'h4);
      check("t4_ovf_before", {31'd0, ovf}, 32'h0);
      btn[1] = 1'b1;
      wait_stable(8'h02, 12, "t4_stable5", n);
      step(3);
      check("t4_count_still4", {29'd0, fcount}, 32'h4);
      check("t4_ovf_set", {31'd0, ovf}, 32'h1);
      evt.ready = 1'b1;
      step(12);
      check("t4_nevents", ev_q.size(), 32'h5);
      if (ev_q.size() == 5) begin
         check("t4_ev0", {28'd0, ev_q[0]}, 32'h3);
         check("t4_ev1", {28'd0, ev_q[1]}, 32'h2);
         check("t4_ev2", {28'd0, ev_q[2]}, 32'h3);
         check("t4_ev3", {28'd0, ev_q[3]}, 32'h2);
         check("t4_ev4", {28'd0, ev_q[4]}, 32'h3);
      end
      check("t4_count_drained", {29'd0, fcount}, 32'h0);
      check("t4_ovf_sticky", {31'd0, ovf}, 32'h1);

      // Overflow clear alone, then clear coinciding with a new overflow.
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("t5_clr_alone", {31'd0, ovf}, 32'h0);
      clear_log();
      evt.ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         btn[1] = (k % 2 == 1);
         wait_stable({6'd0, btn[1], 1'b0}, 12, "t5_stable", n);
         step(3);
      end
      check("t5_count_full", {29'd0, fcount}, 32'h4);
      check("t5_ovf_clear", {31'd0, ovf}, 32'h0);
      clr = 1'b1;
      btn[1] = 1'b0;
      wait_stable(8'h00, 12, "t5_stable5", n);
      check("t5_set_wins", {31'd0, ovf}, 32'h1);
      clr = 1'b0;
      step(1);
      check("t5_sticky", {31'd0, ovf}, 32'h1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("t5_clr_next", {31'd0, ovf}, 32'h0);

      // Reset with two queued events and b4 mid-debounce.
      evt.ready = 1'b1;
      step(12);
      clear_log();
      evt.ready = 1'b0;
      btn[1] = 1'b1;
      wait_stable(8'h02, 12, "t6_stable_a", n);
      step(3);
      btn[1] = 1'b0;
      wait_stable(8'h00, 12, "t6_stable_b", n);
      step(3);
      check("t6_count2", {29'd0, fcount}, 32'h2);
      btn = 8'h10;
      step(5);
      check("t6_mid_debounce", {24'd0, stable}, 32'h00);
      rst = 1'b1;
      step(1);
      check("t6_valid", {31'd0, evt.valid}, 32'h0);
      check("t6_count", {29'd0, fcount}, 32'h0);
      check("t6_stable", {24'd0, stable}, 32'h00);
      check("t6_ovf", {31'd0, ovf}, 32'h0);
      rst = 1'b0;
      evt.ready = 1'b1;
      clear_log();
      wait_stable(8'h10, 20, "t6_b4_stable", n);
      check("t6_full_debounce", n, 32'd12);
      step(2);
      check("t6_valid_b4", {31'd0, evt.valid}, 32'h1);
      check("t6_index_b4", {29'd0, evt.index}, 32'h4);
      check("t6_press_b4", {31'd0, evt.press}, 32'h1);
      step(2);
      check("t6_nevents", ev_q.size(), 32'h1);
      if (ev_q.size() == 1) check("t6_event", {28'd0, ev_q[0]}, 32'h9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
